// File: rtl/fetch_pc_unit.sv
// Fetch-address generator: fixed-priority next-PC selection with a memory handshake.
// Define FETCH_PC_RAS_EN to build in the return-address stack used for call/return prediction.
module fetch_pc_unit #(
    parameter int                    WORD_WIDTH  = 32,
    parameter logic [WORD_WIDTH-1:0] RESET_ADDR  = 32'h0000_0000,
    parameter logic [WORD_WIDTH-1:0] TRAP_VECTOR = 32'h0000_0100,
    parameter int                    INST_BYTES  = 4,
    parameter int                    RAS_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  halt,
    input  logic                  trap,
    input  logic                  redirect,
    input  logic [WORD_WIDTH-1:0] redirect_addr,
    input  logic                  stall,
    input  logic                  fetch_ready,
    input  logic                  pred_taken,
    input  logic [WORD_WIDTH-1:0] pred_addr,
    input  logic                  pred_call,
    input  logic                  pred_ret,
    output logic [WORD_WIDTH-1:0] pc_q,
    output logic                  pc_valid,
    output logic                  ras_empty
);

    localparam logic [WORD_WIDTH-1:0] STEP       = WORD_WIDTH'(INST_BYTES);
    localparam logic [WORD_WIDTH-1:0] ALIGN_MASK = ~(WORD_WIDTH'(INST_BYTES - 1));

    logic                  adv;
    logic                  do_pop;
    logic [WORD_WIDTH-1:0] ras_top;
    logic [WORD_WIDTH-1:0] seq_addr;

    assign adv      = pc_valid & fetch_ready & ~stall;
    assign seq_addr = pc_q + STEP;

`ifdef FETCH_PC_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [WORD_WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]      ras_ptr;
    logic [CNT_W-1:0]      ras_cnt;
    logic                  do_push;
    logic                  ras_frozen;

    assign ras_empty  = (ras_cnt == '0);
    assign do_pop     = adv & pred_ret & ~ras_empty;
    assign do_push    = adv & pred_taken & pred_call;
    assign ras_top    = ras_mem[ras_ptr];
    assign ras_frozen = reset | halt | trap | redirect;

    // ras_ptr indexes the top entry; wrapping lets a push when full overwrite the oldest slot.
    always_ff @(posedge clk) begin
        if (reset || halt || trap) begin
            ras_cnt <= '0;
            ras_ptr <= '0;
        end else if (!redirect) begin
            if (do_pop && !do_push) begin
                ras_ptr <= ras_ptr - 1'b1;
                ras_cnt <= ras_cnt - 1'b1;
            end else if (do_push && !do_pop) begin
                ras_ptr <= ras_ptr + 1'b1;
                if (ras_cnt != CNT_FULL)
                    ras_cnt <= ras_cnt + 1'b1;
            end
        end
    end

    // A combined pop+push rewrites the current top in place.
    always_ff @(posedge clk) begin
        if (!ras_frozen && do_push)
            ras_mem[do_pop ? ras_ptr : ras_ptr + 1'b1] <= seq_addr;
    end
`else
    logic unused_ras_inputs;

    assign unused_ras_inputs = pred_ret ^ pred_call;
    assign ras_empty         = 1'b1;
    assign do_pop            = 1'b0;
    assign ras_top           = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset || halt) begin
            pc_q     <= RESET_ADDR & ALIGN_MASK;
            pc_valid <= 1'b0;
        end else if (trap) begin
            pc_q     <= TRAP_VECTOR & ALIGN_MASK;
            pc_valid <= 1'b1;
        end else if (redirect) begin
            pc_q     <= redirect_addr & ALIGN_MASK;
            pc_valid <= 1'b1;
        end else begin
            pc_valid <= 1'b1;
            if (do_pop)
                pc_q <= ras_top & ALIGN_MASK;
            else if (adv && pred_taken)
                pc_q <= pred_addr & ALIGN_MASK;
            else if (adv)
                pc_q <= seq_addr & ALIGN_MASK;
        end
    end

endmodule
